// File: rtl/inst_rom.sv
// inst_rom: instruction memory with a serial byte loader.
//
// The core fetches words combinationally through ce/addr. A loader streams
// big-endian bytes in over a ld_valid/ld_ready channel after an ld_start
// pulse that carries the word count. While a load is running the fetch
// port returns zero.
//
// Optional feature macro: INST_ROM_CKSUM_EN
//   defined   -> after the data, one checksum byte is accepted in CHECK and
//                compared with the modulo-256 sum of the data bytes; a
//                mismatch sets the sticky ld_err flag.
//   undefined -> no CHECK state, no sum register, ld_err tied low.
//
// Handshake: a byte moves on a rising clk edge where ld_valid=1 and
// ld_ready=1. The source may hold ld_valid low for any number of cycles;
// ld_ready depends only on the FSM state, never on ld_valid.
//
// dbg_state exposes the FSM state: 0=IDLE 1=LOAD 2=CHECK 3=DONE.
module inst_rom #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic        ld_start,
  input  logic [15:0] ld_len,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef INST_ROM_CKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  // State entered once the data words are finished (or skipped for length 0).
`ifdef INST_ROM_CKSUM_EN
  localparam state_t AFTER_LOAD = CHECK;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  state_t       state_q;
  state_t       state_d;
  logic [15:0]  len_q;
  logic [15:0]  word_idx;
  logic [1:0]   byte_idx;
  logic [23:0]  shift_q;
  logic         xfer;
  logic         last_byte;
  logic         last_word;
  logic         start_ok;
  logic         mem_we;
  logic         unused_bits;

  logic [31:0]  mem [0:DEPTH-1];

  assign xfer      = ld_valid & ld_ready;
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx == (len_q - 16'd1));
  assign start_ok  = (state_q == IDLE) & ld_start;

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    ld_busy  = 1'b1;
    ld_done  = 1'b0;
    case (state_q)
      IDLE: begin
        ld_busy = 1'b0;
        if (ld_start) begin
          if (ld_len == 16'd0) state_d = AFTER_LOAD;
          else                 state_d = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (xfer && last_byte && last_word) state_d = AFTER_LOAD;
      end
`ifdef INST_ROM_CKSUM_EN
      CHECK: begin
        ld_ready = 1'b1;
        if (xfer) state_d = DONE;
      end
`endif
      DONE: begin
        ld_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM register plus word/byte counters and the byte assembly register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      len_q    <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      shift_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q    <= ld_len;
        word_idx <= 16'd0;
        byte_idx <= 2'd0;
      end else if (state_q == LOAD && xfer) begin
        byte_idx <= byte_idx + 2'd1;
        shift_q  <= {shift_q[15:0], ld_byte};
        if (last_byte) word_idx <= word_idx + 16'd1;
      end
    end
  end

`ifdef INST_ROM_CKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  // Running data-byte sum and the sticky checksum error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else if (state_q == LOAD && xfer) begin
      sum_q <= sum_q + ld_byte;
    end else if (state_q == CHECK && xfer && (ld_byte != sum_q)) begin
      err_q <= 1'b1;
    end
  end

  assign ld_err = err_q;
`else
  assign ld_err = 1'b0;
`endif

  // Reset blocks the write so an aborting reset cannot land a partial word.
  assign mem_we = rst & (state_q == LOAD) & xfer & last_byte;

  // Memory array: never reset, so words from an aborted load survive.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx[DEPTH_LOG2-1:0]] <= {shift_q, ld_byte};
  end

  // Fetch port: word aligned, upper address bits wrap onto the array.
  assign inst = (ce && !ld_busy) ? mem[addr[DEPTH_LOG2+1:2]] : 32'd0;

  assign dbg_state = state_q;

  // Byte offset, wrapped address bits and high word-index bits are unused
  // (word index stays 16 bits wide to compare against the full length).
  assign unused_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0], word_idx[15:DEPTH_LOG2]};

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: loads, checksum, fetch gating, aborting
// reset, zero-length load and address wrap. Works with or without
// INST_ROM_CKSUM_EN defined.
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        ld_start;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;
  logic [1:0]  dbg_state;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

`ifdef INST_ROM_CKSUM_EN
  localparam logic [31:0] CK_ERR  = 32'd1;
`else
  localparam logic [31:0] CK_ERR  = 32'd0;
`endif

  inst_rom #(.DEPTH_LOG2(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .addr      (addr),
    .inst      (inst),
    .ld_start  (ld_start),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Count ld_done cycles, sampled away from the active edge.
  always @(negedge clk) if (ld_done) done_cnt++;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_load(input logic [15:0] len);
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = len;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  // Presents one byte for exactly one accepting edge (bounded ready wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_byte", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_byte  = b;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic send_cksum(input logic [7:0] b);
`ifdef INST_ROM_CKSUM_EN
    check_eq("state_check", 32'(dbg_state), 32'd2);
    send_byte(b);
`else
    ld_byte = b;
`endif
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce   = 1'b1;
    addr = a;
    #1;
    check_eq(tag, inst, exp);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; addr = 32'd0;
    ld_start = 1'b0; ld_len = 16'd0; ld_valid = 1'b0; ld_byte = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_busy",  32'(ld_busy),   32'd0);
    check_eq("rst_ready", 32'(ld_ready),  32'd0);
    check_eq("rst_done",  32'(ld_done),   32'd0);
    check_eq("rst_err",   32'(ld_err),    32'd0);
    check_eq("rst_inst_ce0", inst, 32'd0);
    rst = 1'b1;

    // Single word, good checksum 0x3D
    ce = 1'b1; addr = 32'd0;
    start_load(16'd1);
    check_eq("t1_state_load", 32'(dbg_state), 32'd1);
    check_eq("t1_busy",  32'(ld_busy), 32'd1);
    check_eq("t1_inst_busy", inst, 32'd0);
    send_byte(8'h34); send_byte(8'h08); send_byte(8'h00); send_byte(8'h01);
    send_cksum(8'h3D);
    check_eq("t1_state_done", 32'(dbg_state), 32'd3);
    check_eq("t1_done",  32'(ld_done), 32'd1);
    check_eq("t1_ready_done", 32'(ld_ready), 32'd0);
    read_word("t1_inst_in_done", 32'h0000_0000, 32'd0);
    idle_cycle();
    check_eq("t1_state_idle", 32'(dbg_state), 32'd0);
    check_eq("t1_done_low", 32'(ld_done), 32'd0);
    check_eq("t1_err", 32'(ld_err), 32'd0);
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    read_word("t1_mem0", 32'h0000_0000, 32'h3408_0001);
    ce = 1'b0;
    #1;
    check_eq("t1_inst_ce0", inst, 32'd0);

    // Single word, bad checksum: word still written, error sticky
    start_load(16'd1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_cksum(8'h00);
    idle_cycle();
    check_eq("t2_err", 32'(ld_err), CK_ERR);
    repeat (3) idle_cycle();
    check_eq("t2_err_sticky", 32'(ld_err), CK_ERR);
    check_eq("t2_done_cnt", 32'(done_cnt), 32'd2);
    read_word("t2_mem0", 32'h0000_0000, 32'h1234_5678);

    // Two words with ld_valid low every other cycle; stray ld_start ignored
    start_load(16'd2);
    check_eq("t3_err_cleared", 32'(ld_err), 32'd0);
    read_word("t3_inst_busy", 32'h0000_0004, 32'd0);
    send_byte(8'h11); idle_cycle();
    send_byte(8'h22);
    @(negedge clk);
    ld_start = 1'b1; ld_len = 16'd0;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    check_eq("t3_start_ignored", 32'(dbg_state), 32'd1);
    send_byte(8'h33); idle_cycle();
    send_byte(8'h44); idle_cycle();
    send_byte(8'h55); idle_cycle();
    send_byte(8'h66); idle_cycle();
    send_byte(8'h77); idle_cycle();
    check_eq("t3_still_load", 32'(dbg_state), 32'd1);
    send_byte(8'h88);
    send_cksum(8'h64);
    check_eq("t3_state_done", 32'(dbg_state), 32'd3);
    idle_cycle();
    check_eq("t3_err", 32'(ld_err), 32'd0);
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd3);
    read_word("t3_mem0", 32'h0000_0000, 32'h1122_3344);
    read_word("t3_mem1", 32'h0000_0004, 32'h5566_7788);
    read_word("t3_mem1_offset", 32'h0000_0007, 32'h5566_7788);

    // Reset after 2 of 4 bytes of word 1, with a byte presented in the reset cycle
    start_load(16'd2);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h01); send_byte(8'h02);
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b1; ld_byte = 8'h03;
    @(posedge clk);
    #1;
    rst = 1'b1; ld_valid = 1'b0;
    check_eq("t4_state_idle", 32'(dbg_state), 32'd0);
    check_eq("t4_busy", 32'(ld_busy), 32'd0);
    check_eq("t4_ready", 32'(ld_ready), 32'd0);
    // Reset wins over ld_start
    @(negedge clk);
    rst = 1'b0; ld_start = 1'b1; ld_len = 16'd1;
    @(posedge clk);
    #1;
    rst = 1'b1; ld_start = 1'b0;
    check_eq("t4_rst_over_start", 32'(dbg_state), 32'd0);
    read_word("t4_mem0_kept", 32'h0000_0000, 32'hDEAD_BEEF);
    read_word("t4_mem1_unchanged", 32'h0000_0004, 32'h5566_7788);
    check_eq("t4_done_cnt", 32'(done_cnt), 32'd3);

    // Zero-length load, then wrapped addresses
    ce = 1'b1; addr = 32'h0000_1000;
    start_load(16'd0);
`ifdef INST_ROM_CKSUM_EN
    check_eq("t5_state_check", 32'(dbg_state), 32'd2);
    send_byte(8'h00);
`endif
    check_eq("t5_state_done", 32'(dbg_state), 32'd3);
    check_eq("t5_done", 32'(ld_done), 32'd1);
    idle_cycle();
    check_eq("t5_state_idle", 32'(dbg_state), 32'd0);
    check_eq("t5_err", 32'(ld_err), 32'd0);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd4);
    read_word("t5_wrap_mem0", 32'h0000_1000, 32'hDEAD_BEEF);
    read_word("t5_wrap_mem1", 32'hFFFF_F004, 32'h5566_7788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
